uart_rx_cmd_parser: RTL and testbench

Byte-level command-frame parser sitting directly downstream of the UART receiver. It consumes each received byte (DATA_VALID pulse plus parity/stop error flags) and assembles multi-byte frames into one decoded command: register write, register read, ALU with operands, or ALU without operands. It presents that command to the system controller over a valid/ready handshake and flags malformed, errored, timed-out or overrun frames.

---
 rtl/uart_rx_cmd_parser_if.sv | 32 +++
 rtl/uart_rx_cmd_parser.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_cmd_parser.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_cmd_parser_if.sv
// Byte stream from the UART receiver and the decoded-command / error outputs
// of the command-frame parser.
interface uart_rx_cmd_parser_if #(
    parameter int ADDR_WIDTH = 4
);
    logic [7:0]            rx_p_data;
    logic                  rx_d_vld;
    logic                  rx_par_err;
    logic                  rx_stp_err;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_type;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            cmd_wdata;
    logic [7:0]            cmd_opa;
    logic [7:0]            cmd_opb;
    logic [3:0]            cmd_func;
    logic                  frame_err;
    logic [1:0]            err_code;

    modport master (
        output rx_p_data, rx_d_vld, rx_par_err, rx_stp_err, cmd_ready,
        input  cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_opa, cmd_opb,
               cmd_func, frame_err, err_code
    );

    modport slave (
        input  rx_p_data, rx_d_vld, rx_par_err, rx_stp_err, cmd_ready,
        output cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_opa, cmd_opb,
               cmd_func, frame_err, err_code
    );
endinterface

// File: rtl/uart_rx_cmd_parser.sv
// Assembles UART bytes into write/read/ALU commands, hands them out over a
// valid/ready handshake and pulses frame_err on malformed or lost frames.
module uart_rx_cmd_parser #(
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_rx_cmd_parser_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_GET_ADDR  = 3'd1;
    localparam logic [2:0] ST_GET_WDATA = 3'd2;
    localparam logic [2:0] ST_GET_OPA   = 3'd3;
    localparam logic [2:0] ST_GET_OPB   = 3'd4;
    localparam logic [2:0] ST_GET_FUNC  = 3'd5;
    localparam logic [2:0] ST_OUT_HOLD  = 3'd6;

    localparam logic [7:0] HDR_WRITE  = 8'hAA;
    localparam logic [7:0] HDR_READ   = 8'hBB;
    localparam logic [7:0] HDR_ALU_OP = 8'hCC;
    localparam logic [7:0] HDR_ALU    = 8'hDD;

    localparam logic [1:0] TYPE_WRITE  = 2'd0;
    localparam logic [1:0] TYPE_READ   = 2'd1;
    localparam logic [1:0] TYPE_ALU_OP = 2'd2;
    localparam logic [1:0] TYPE_ALU    = 2'd3;

    localparam logic [1:0] ERR_UNKNOWN = 2'd0;
    localparam logic [1:0] ERR_BYTE    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    function automatic logic byte_bad(input logic par_err, input logic stp_err);
        return par_err | stp_err;
    endfunction

    logic [2:0]            state_r,     state_s;
    logic [CNT_W-1:0]      gap_cnt_r,   gap_cnt_s;
    logic                  cmd_valid_r, cmd_valid_s;
    logic [1:0]            cmd_type_r,  cmd_type_s;
    logic [ADDR_WIDTH-1:0] cmd_addr_r,  cmd_addr_s;
    logic [7:0]            cmd_wdata_r, cmd_wdata_s;
    logic [7:0]            cmd_opa_r,   cmd_opa_s;
    logic [7:0]            cmd_opb_r,   cmd_opb_s;
    logic [3:0]            cmd_func_r,  cmd_func_s;
    logic                  frame_err_r, frame_err_s;
    logic [1:0]            err_code_r,  err_code_s;
    logic                  take_byte_s;

    // Next-state, field capture and error decode for one received byte per cycle.
    always_comb begin
        state_s     = state_r;
        gap_cnt_s   = gap_cnt_r;
        cmd_valid_s = cmd_valid_r;
        cmd_type_s  = cmd_type_r;
        cmd_addr_s  = cmd_addr_r;
        cmd_wdata_s = cmd_wdata_r;
        cmd_opa_s   = cmd_opa_r;
        cmd_opb_s   = cmd_opb_r;
        cmd_func_s  = cmd_func_r;
        frame_err_s = 1'b0;
        err_code_s  = err_code_r;
        take_byte_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                take_byte_s = bus.rx_d_vld;
            end
            ST_OUT_HOLD: begin
                gap_cnt_s = {CNT_W{1'b0}};
                if (bus.cmd_ready) begin
                    cmd_valid_s = 1'b0;
                    state_s     = ST_IDLE;
                    take_byte_s = bus.rx_d_vld;
                end else if (bus.rx_d_vld) begin
                    frame_err_s = 1'b1;
                    err_code_s  = ERR_OVERRUN;
                end else begin
                    frame_err_s = 1'b0;
                end
            end
            default: begin
                // A byte landing on the expiry cycle takes precedence over the timeout.
                if (bus.rx_d_vld) begin
                    take_byte_s = 1'b1;
                end else if (gap_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    frame_err_s = 1'b1;
                    err_code_s  = ERR_TIMEOUT;
                    state_s     = ST_IDLE;
                    gap_cnt_s   = {CNT_W{1'b0}};
                end else begin
                    gap_cnt_s = gap_cnt_r + CNT_W'(1);
                end
            end
        endcase

        if (take_byte_s) begin
            gap_cnt_s = {CNT_W{1'b0}};
            if (byte_bad(bus.rx_par_err, bus.rx_stp_err)) begin
                frame_err_s = 1'b1;
                err_code_s  = ERR_BYTE;
                state_s     = ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE, ST_OUT_HOLD: begin
                        cmd_addr_s  = {ADDR_WIDTH{1'b0}};
                        cmd_wdata_s = 8'h00;
                        cmd_opa_s   = 8'h00;
                        cmd_opb_s   = 8'h00;
                        cmd_func_s  = 4'h0;
                        case (bus.rx_p_data)
                            HDR_WRITE:  begin cmd_type_s = TYPE_WRITE;  state_s = ST_GET_ADDR; end
                            HDR_READ:   begin cmd_type_s = TYPE_READ;   state_s = ST_GET_ADDR; end
                            HDR_ALU_OP: begin cmd_type_s = TYPE_ALU_OP; state_s = ST_GET_OPA;  end
                            HDR_ALU:    begin cmd_type_s = TYPE_ALU;    state_s = ST_GET_FUNC; end
                            default: begin
                                frame_err_s = 1'b1;
                                err_code_s  = ERR_UNKNOWN;
                                state_s     = ST_IDLE;
                            end
                        endcase
                    end
                    ST_GET_ADDR: begin
                        cmd_addr_s = bus.rx_p_data[ADDR_WIDTH-1:0];
                        if (cmd_type_r == TYPE_WRITE) begin
                            state_s = ST_GET_WDATA;
                        end else begin
                            state_s     = ST_OUT_HOLD;
                            cmd_valid_s = 1'b1;
                        end
                    end
                    ST_GET_WDATA: begin
                        cmd_wdata_s = bus.rx_p_data;
                        state_s     = ST_OUT_HOLD;
                        cmd_valid_s = 1'b1;
                    end
                    ST_GET_OPA: begin
                        cmd_opa_s = bus.rx_p_data;
                        state_s   = ST_GET_OPB;
                    end
                    ST_GET_OPB: begin
                        cmd_opb_s = bus.rx_p_data;
                        state_s   = ST_GET_FUNC;
                    end
                    ST_GET_FUNC: begin
                        cmd_func_s  = bus.rx_p_data[3:0];
                        state_s     = ST_OUT_HOLD;
                        cmd_valid_s = 1'b1;
                    end
                    default: begin
                        state_s = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // State and output registers; reset silently discards any partial or held frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            gap_cnt_r   <= {CNT_W{1'b0}};
            cmd_valid_r <= 1'b0;
            cmd_type_r  <= 2'd0;
            cmd_addr_r  <= {ADDR_WIDTH{1'b0}};
            cmd_wdata_r <= 8'h00;
            cmd_opa_r   <= 8'h00;
            cmd_opb_r   <= 8'h00;
            cmd_func_r  <= 4'h0;
            frame_err_r <= 1'b0;
            err_code_r  <= 2'd0;
        end else begin
            state_r     <= state_s;
            gap_cnt_r   <= gap_cnt_s;
            cmd_valid_r <= cmd_valid_s;
            cmd_type_r  <= cmd_type_s;
            cmd_addr_r  <= cmd_addr_s;
            cmd_wdata_r <= cmd_wdata_s;
            cmd_opa_r   <= cmd_opa_s;
            cmd_opb_r   <= cmd_opb_s;
            cmd_func_r  <= cmd_func_s;
            frame_err_r <= frame_err_s;
            err_code_r  <= err_code_s;
        end
    end

    assign bus.cmd_valid = cmd_valid_r;
    assign bus.cmd_type  = cmd_type_r;
    assign bus.cmd_addr  = cmd_addr_r;
    assign bus.cmd_wdata = cmd_wdata_r;
    assign bus.cmd_opa   = cmd_opa_r;
    assign bus.cmd_opb   = cmd_opb_r;
    assign bus.cmd_func  = cmd_func_r;
    assign bus.frame_err = frame_err_r;
    assign bus.err_code  = err_code_r;
endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Directed bench for uart_rx_cmd_parser: frames, stalls, errors, timeout,
// back-to-back handshake and mid-frame reset, with a short 50-cycle timeout.
module tb_uart_rx_cmd_parser;
    localparam int AW = 4;
    localparam int TO = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    uart_rx_cmd_parser_if #(.ADDR_WIDTH(AW)) bus ();

    uart_rx_cmd_parser #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cmd(input string tag, input logic v, input logic [1:0] t,
                             input logic [3:0] a, input logic [7:0] wd,
                             input logic [7:0] oa, input logic [7:0] ob,
                             input logic [3:0] f, input logic fe);
        check({tag, ".valid"}, {7'd0, bus.cmd_valid}, {7'd0, v});
        check({tag, ".type"},  {6'd0, bus.cmd_type},  {6'd0, t});
        check({tag, ".addr"},  {4'd0, bus.cmd_addr},  {4'd0, a});
        check({tag, ".wdata"}, bus.cmd_wdata, wd);
        check({tag, ".opa"},   bus.cmd_opa, oa);
        check({tag, ".opb"},   bus.cmd_opb, ob);
        check({tag, ".func"},  {4'd0, bus.cmd_func}, {4'd0, f});
        check({tag, ".ferr"},  {7'd0, bus.frame_err}, {7'd0, fe});
    endtask

    task automatic check_err(input string tag, input logic fe, input logic [1:0] code);
        check({tag, ".ferr"}, {7'd0, bus.frame_err}, {7'd0, fe});
        check({tag, ".code"}, {6'd0, bus.err_code},  {6'd0, code});
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic pe, input logic se);
        bus.rx_p_data  = b;
        bus.rx_d_vld   = 1'b1;
        bus.rx_par_err = pe;
        bus.rx_stp_err = se;
        @(posedge clk);
        #1;
        bus.rx_d_vld   = 1'b0;
        bus.rx_par_err = 1'b0;
        bus.rx_stp_err = 1'b0;
    endtask

    initial begin
        bus.rx_p_data  = 8'h00;
        bus.rx_d_vld   = 1'b0;
        bus.rx_par_err = 1'b0;
        bus.rx_stp_err = 1'b0;
        bus.cmd_ready  = 1'b0;

        // Reset state
        step(2);
        check_cmd("reset", 1'b0, 2'd0, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0);
        check_err("reset", 1'b0, 2'd0);
        rst = 1'b0;
        step(1);

        // Write frame with ready tied high: single-cycle valid
        bus.cmd_ready = 1'b1;
        send(8'hAA, 1'b0, 1'b0);
        send(8'h05, 1'b0, 1'b0);
        check("wr.novalid_early", {7'd0, bus.cmd_valid}, 8'h00);
        send(8'h3C, 1'b0, 1'b0);
        check_cmd("wr", 1'b1, 2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 1'b0);
        step(1);
        check("wr.pulse_end", {7'd0, bus.cmd_valid}, 8'h00);

        // ALU frame held by a stalled consumer, with an overrun byte injected
        bus.cmd_ready = 1'b0;
        send(8'hCC, 1'b0, 1'b0);
        send(8'h12, 1'b0, 1'b0);
        send(8'h34, 1'b0, 1'b0);
        send(8'h07, 1'b0, 1'b0);
        check_cmd("alu", 1'b1, 2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h7, 1'b0);
        step(4);
        send(8'hDD, 1'b0, 1'b0);
        check_err("overrun", 1'b1, 2'd3);
        check_cmd("alu.held", 1'b1, 2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h7, 1'b1);
        step(5);
        check_cmd("alu.stall10", 1'b1, 2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h7, 1'b0);
        bus.cmd_ready = 1'b1;
        step(1);
        check("alu.accepted", {7'd0, bus.cmd_valid}, 8'h00);

        // Byte error aborts a read frame, then unknown header, then a good read
        send(8'hBB, 1'b0, 1'b0);
        send(8'h05, 1'b1, 1'b0);
        check_err("byte_err", 1'b1, 2'd1);
        check("byte_err.novalid", {7'd0, bus.cmd_valid}, 8'h00);
        send(8'h55, 1'b0, 1'b0);
        check_err("unknown", 1'b1, 2'd0);
        check("unknown.novalid", {7'd0, bus.cmd_valid}, 8'h00);
        send(8'hBB, 1'b0, 1'b0);
        check("rd.ferr_clear", {7'd0, bus.frame_err}, 8'h00);
        send(8'h0F, 1'b0, 1'b0);
        check_cmd("rd", 1'b1, 2'd1, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0);
        step(1);

        // Timeout: gap of TO cycles after the address byte
        send(8'hAA, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        step(TO - 1);
        check("to.not_yet", {7'd0, bus.frame_err}, 8'h00);
        step(1);
        check_err("to.fire", 1'b1, 2'd2);
        check("to.novalid", {7'd0, bus.cmd_valid}, 8'h00);
        step(1);
        check_err("to.pulse_end", 1'b0, 2'd2);
        send(8'hDD, 1'b0, 1'b0);
        send(8'h01, 1'b0, 1'b0);
        check_cmd("to.idle_after", 1'b1, 2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h1, 1'b0);
        step(1);

        // Byte arriving exactly on the expiry cycle wins
        send(8'hAA, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        step(TO - 1);
        send(8'h3C, 1'b0, 1'b0);
        check_cmd("to.edge", 1'b1, 2'd0, 4'h2, 8'h3C, 8'h00, 8'h00, 4'h0, 1'b0);
        step(1);
        check("to.edge.after", {7'd0, bus.frame_err}, 8'h00);

        // Back-to-back: new header on the handshake cycle
        bus.cmd_ready = 1'b0;
        send(8'hDD, 1'b0, 1'b0);
        send(8'h0A, 1'b0, 1'b0);
        check_cmd("b2b.first", 1'b1, 2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'hA, 1'b0);
        bus.cmd_ready = 1'b1;
        send(8'hDD, 1'b0, 1'b0);
        check_cmd("b2b.mid", 1'b0, 2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0);
        send(8'h03, 1'b0, 1'b0);
        check_cmd("b2b.second", 1'b1, 2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3, 1'b0);
        step(1);

        // Reset mid-frame discards the partial ALU frame silently
        send(8'hCC, 1'b0, 1'b0);
        send(8'h11, 1'b0, 1'b0);
        rst = 1'b1;
        step(1);
        check_cmd("rst_mid", 1'b0, 2'd0, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0);
        check_err("rst_mid", 1'b0, 2'd0);
        rst = 1'b0;
        send(8'hDD, 1'b0, 1'b0);
        check("rst_mid.noerr", {7'd0, bus.frame_err}, 8'h00);
        send(8'h04, 1'b0, 1'b0);
        check_cmd("rst_mid.cmd", 1'b1, 2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h4, 1'b0);
        check_err("rst_mid.cmd", 1'b0, 2'd0);
        step(1);
        check("rst_mid.single", {7'd0, bus.cmd_valid}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
